// File: rtl/seg7_scan_driver.sv
// Multiplexed hex driver for common-anode 7-segment banks. A frame-aligned
// double buffer feeds a registered scan stage that lights one digit per REFRESH_DIV cycles.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                blank_lz,
    input  logic                en,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]       div_cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;
    logic [4*DIGITS-1:0] active_val;
    logic [DIGITS-1:0]   active_dp;
    logic                pending;

    logic                tick;
    logic                boundary;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_lz;
    logic [DIGITS-1:0]   lz_vec;
    logic                zero_above;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign tick     = (div_cnt == CW'(REFRESH_DIV - 1));
    assign boundary = tick && (idx == IW'(DIGITS - 1));

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        zero_above = 1'b1;
        lz_vec     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (active_val[4*i +: 4] == 4'h0);
            lz_vec[i]  = zero_above && (i != 0);
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib = active_val[4*i +: 4];
                cur_dp  = active_dp[i];
                cur_lz  = lz_vec[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (tick) begin
                div_cnt <= '0;
                idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
        end
    end

    // Double buffer: a load coinciding with the boundary bypasses the shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end
            if (boundary) begin
                if (load) begin
                    active_val <= value;
                    active_dp  <= dp_in;
                end else if (pending) begin
                    active_val <= shadow_val;
                    active_dp  <= shadow_dp;
                end
                pending <= 1'b0;
            end
        end
    end

    // Output stage: pins follow idx/active by one clock.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            an  <= '1;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= (blank_lz && cur_lz) ? 7'b1111111 : hex_to_seg(cur_nib);
            dp  <= ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count reference model queues
// the expected pin state per clock and a monitor compares on the falling edge.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int RD = 4;
    localparam int FRAME = D * RD;
    localparam logic [6:0] SEGTAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic          blank_lz = 1'b0;
    logic          en = 1'b1;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_done;

    seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .en(en), .seg(seg), .dp(dp), .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference state: k counts edges since reset release.
    int          k = 0;
    logic [15:0] m_val = '0, sh_val = '0;
    logic [3:0]  m_dp = '0, sh_dp = '0;
    bit          m_pend = 0;
    logic [12:0] exp_q[$];
    int          checks = 0;
    int          passes = 0;

    task automatic model_edge();
        logic [12:0] e;
        logic [3:0]  an_e;
        logic [6:0]  seg_e;
        logic        dp_e;
        logic        fd_e;
        logic [15:0] upper;
        int          dg;
        if (rst) begin
            k = 0; m_val = '0; m_dp = '0; sh_val = '0; sh_dp = '0; m_pend = 0;
            e = {4'hF, 7'h7F, 1'b1, 1'b0};
        end else begin
            k++;
            dg    = ((k - 1) / RD) % D;
            fd_e  = (k % FRAME) == 0;
            upper = m_val >> (4 * dg);
            if (!en) begin
                an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
            end else begin
                an_e  = 4'hF & ~(4'b0001 << dg);
                seg_e = (blank_lz && dg > 0 && upper == 16'h0) ? 7'h7F : SEGTAB[upper[3:0]];
                dp_e  = ~m_dp[dg];
            end
            e = {an_e, seg_e, dp_e, fd_e};
            if (load) begin
                sh_val = value; sh_dp = dp_in; m_pend = 1;
            end
            if (fd_e && m_pend) begin
                m_val = sh_val; m_dp = sh_dp; m_pend = 0;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d);
        rst = r; load = ld; value = v; dp_in = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic run_to_phase(input int ph);
        for (int i = 0; i < FRAME && (k % FRAME) != ph; i++) idle(1);
    endtask

    initial begin : monitor
        logic [12:0] e, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {an, seg, dp, frame_done};
                checks++;
                if (got === e) passes++;
                else $display("FAIL pins k=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                              k, got[12:9], got[8:2], got[1], got[0], e[12:9], e[8:2], e[1], e[0]);
            end
        end
    end

    initial begin : stim
        step(1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        idle(34);
        run_to_phase(6);
        step(1'b0, 1'b1, 16'h1A3F, 4'h0);
        idle(40);
        blank_lz = 1'b1;
        step(1'b0, 1'b1, 16'h0050, 4'h0);
        idle(36);
        step(1'b0, 1'b1, 16'h0000, 4'h0);
        idle(36);
        blank_lz = 1'b0;
        run_to_phase(3);
        step(1'b0, 1'b1, 16'h1111, 4'h0);
        idle(4);
        step(1'b0, 1'b1, 16'h2222, 4'h0);
        idle(24);
        run_to_phase(FRAME - 1);
        step(1'b0, 1'b1, 16'h4567, 4'h0);
        idle(20);
        step(1'b0, 1'b1, 16'h89CD, 4'b0100);
        idle(36);
        en = 1'b0;
        idle(20);
        en = 1'b1;
        idle(10);
        run_to_phase(5);
        step(1'b0, 1'b1, 16'hBEEF, 4'b1111);
        idle(3);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        idle(36);
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) blank_lz = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 9) != 0);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0),
                 16'($urandom), 4'($urandom));
        end
        #2;
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed hex display driver for common-anode 7-segment banks. It decodes a packed value of DIGITS hex nibbles and scans one digit at a time at a divided refresh rate. New values are double-buffered so a digit update never tears mid-frame. It sits between arithmetic datapaths (e.g. multiplier result/BCD converter) and the board's segment/anode pins.

## Interface
- DIGITS, 4: number of digits scanned (1..8).
- REFRESH_DIV, 50000: clk cycles each digit stays lit (>= 2).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- load  in  1  one-cycle strobe; capture value and dp_in.
- value  in  4*DIGITS  packed nibbles, digit i = value[4i+3:4i], digit 0 rightmost.
- dp_in  in  DIGITS  decimal-point request per digit, active-high.
- blank_lz  in  1  enable leading-zero blanking.
- en  in  1  display enable; 0 = all digits dark.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  DIGITS  digit anode selects, active-low, one-hot-low when lit.
- frame_done  out  1  one-cycle pulse at each scan wrap.

## Operation
- Registers: div_cnt (0..REFRESH_DIV-1), idx (0..DIGITS-1), shadow value/dp, active value/dp, pending flag.
- Tick: div_cnt == REFRESH_DIV-1 -> div_cnt <= 0, idx <= idx+1 (wraps DIGITS-1 -> 0); else div_cnt++.
- Frame boundary: tick with idx == DIGITS-1. frame_done <= 1 for that cycle's next edge only.
- load: shadow <= {value, dp_in}, pending <= 1. Repeated loads before a boundary: last wins.
- At frame boundary with pending: active <= shadow, pending <= 0. load in the same cycle as a boundary: active <= the new value/dp_in directly, pending <= 0.
- Decode (active-low, abcdefg): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Leading-zero blanking: with blank_lz=1, digit i>0 is blanked when nibbles i..DIGITS-1 of active are all zero; digit 0 never blanked. Blanked digit: seg=1111111, dp still driven from active dp.
- en=0: an all ones, seg=1111111, dp=1; counters, idx, load path keep running.
- Output stage: an/seg/dp registered from idx and active; an[idx]=0, others 1.

## Timing
- Reset values: div_cnt=0, idx=0, shadow=0, active=0, pending=0, seg=1111111, dp=1, an=all ones, frame_done=0.
- Outputs lag idx by exactly one clock; on first edge after rst released with en=1, an selects digit 0 showing "0".
- Each digit lit for exactly REFRESH_DIV cycles; frame period DIGITS*REFRESH_DIV cycles.
- load-to-display latency: until next frame boundary plus one cycle; never mid-frame.
- rst asserted mid-frame: all state returns to reset values on that edge, pending load discarded.
- en toggles take effect one cycle later; no effect on frame alignment.

## Test plan
- DIGITS=4, REFRESH_DIV=4, rst 2 cycles, en=1 -> an sequence 1110,1101,1011,0111 each 4 cycles, seg=0000001, frame_done every 16 cycles.
- load value=16'h1A3F mid-frame -> display unchanged until wrap; next frame digits 0..3 show 0111000,0000110,0001000,1001111.
- blank_lz=1, load 16'h0050 -> digits 3,2 seg=1111111, digit 1=0100100, digit 0=0000001; with value 0 only digit 0 lit as "0".
- Two loads (16'h1111 then 16'h2222) in one frame -> next frame shows only 2222; load coincident with boundary -> visible next frame immediately.
- dp_in=4'b0100 -> dp=0 only while an=1011; en=0 -> an=1111, seg=1111111, dp=1, frame_done still pulses.
- rst mid-frame with pending load -> next cycle reset values; following frame shows 0000, not the pending value.
